mat_mul_sched: RTL and testbench

MAT_MUL_SCHED -- requirements
Module: mat_mul_sched

---
 rtl/mat_mul_sched.sv | 171 +++++++++++++++++
 tb/tb_mat_mul_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : mat_mul_sched
// Description : Two-requester round-robin scheduler for a 3x3 matrix-multiply
//               engine. Optional watchdog enabled by MAT_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_mul_sched #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [9*DATA_W-1:0]  req_a0,
  input  logic [9*DATA_W-1:0]  req_a1,
  input  logic [9*DATA_W-1:0]  req_b0,
  input  logic [9*DATA_W-1:0]  req_b1,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [18*DATA_W-1:0] rsp_c,
  output logic                 rsp_err,
  output logic                 eng_en,
  output logic                 eng_trig,
  output logic [9*DATA_W-1:0]  eng_din_A,
  output logic [9*DATA_W-1:0]  eng_din_B,
  input  logic [18*DATA_W-1:0] eng_dout_C,
  input  logic                 eng_out_vld,
  output logic                 busy
);

  localparam int c_OP_W  = 9*DATA_W;
  localparam int c_RES_W = 18*DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_prio;
  logic                r_id;
  logic [c_OP_W-1:0]   r_a;
  logic [c_OP_W-1:0]   r_b;
  logic [c_RES_W-1:0]  r_c;
  logic                w_gnt_id;
  logic [1:0]          w_gnt;
  logic                w_accept;
  logic                w_done;
  logic                w_tmo;

  // The priority holder wins when valid; otherwise the other requester.
  always_comb begin
    w_gnt_id = r_prio;
    if (!req_valid[r_prio] && req_valid[~r_prio]) begin
      w_gnt_id = ~r_prio;
    end
    w_gnt = 2'b00;
    if (r_state == IDLE && rst_n && (|req_valid)) begin
      w_gnt = w_gnt_id ? 2'b10 : 2'b01;
    end
  end

  assign req_ready = w_gnt;
  assign w_accept  = |(req_valid & w_gnt);
  assign w_done    = (r_state == RUN) && eng_out_vld;

`ifdef MAT_SCHED_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT + 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == LOAD) begin
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  // Fires on the TIMEOUT-th RUN cycle; a simultaneous completion wins.
  assign w_tmo = (r_state == RUN) && !eng_out_vld && (r_cnt == c_CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_done) begin
      r_err <= 1'b0;
    end else if (w_tmo) begin
      r_err <= 1'b1;
    end
  end

  assign rsp_err = r_err;
`else
  assign w_tmo   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    eng_en      = 1'b0;
    eng_trig    = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = LOAD;
      end
      LOAD: begin
        eng_en      = 1'b1;
        eng_trig    = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        eng_en = 1'b1;
        if (w_done || w_tmo) w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
      r_id   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
    end else begin
      if (w_accept) begin
        r_prio <= ~w_gnt_id;
        r_id   <= w_gnt_id;
        r_a    <= w_gnt_id ? req_a1 : req_a0;
        r_b    <= w_gnt_id ? req_b1 : req_b0;
      end
      if (w_done) begin
        r_c <= eng_dout_C;
      end else if (w_tmo) begin
        r_c <= '0;
      end
    end
  end

  assign eng_din_A = r_a;
  assign eng_din_B = r_b;
  assign rsp_id    = r_id;
  assign rsp_c     = r_c;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mat_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mat_mul_sched
// Description : Directed/randomized self-checking bench for mat_mul_sched with
//               an engine stub; watchdog steps run when MAT_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_mul_sched;

  localparam int DW = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     req_valid = 2'b00;
  logic [1:0]     req_ready;
  logic [9*DW-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic           rsp_id;
  logic [18*DW-1:0] rsp_c;
  logic           rsp_err;
  logic           eng_en, eng_trig;
  logic [9*DW-1:0] eng_din_A, eng_din_B;
  logic [18*DW-1:0] eng_dout_C = '0;
  logic           eng_out_vld;
  logic           busy;

  logic           stub_vld = 1'b0;
  logic           stray = 1'b0;
  logic           stub_silent = 1'b0;
  int             stub_lat = 1;
  int             stub_cnt = 0;
  logic [18*DW-1:0] stub_res = '0;
  int             trig_cnt = 0;

  int             total = 0;
  int             bad = 0;
  bit             rr_ptr = 1'b0;

  assign eng_out_vld = stub_vld | stray;

  mat_mul_sched #(.DATA_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(a0), .req_a1(a1), .req_b0(b0), .req_b1(b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_err(rsp_err),
    .eng_en(eng_en), .eng_trig(eng_trig),
    .eng_din_A(eng_din_A), .eng_din_B(eng_din_B),
    .eng_dout_C(eng_dout_C), .eng_out_vld(eng_out_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  // C[i][j] = sum_k A[i][k] * B[k][j]; B arrives transposed, C is row-major.
  function automatic logic [18*DW-1:0] ref_mul(input logic [9*DW-1:0] a, input logic [9*DW-1:0] bt);
    logic [18*DW-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int unsigned s;
        s = 0;
        for (int k = 0; k < 3; k++) begin
          s += int'(a[(i*3+k)*DW +: DW]) * int'(bt[(j*3+k)*DW +: DW]);
        end
        r[(i*3+j)*2*DW +: 2*DW] = s[2*DW-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [9*DW-1:0] rnd_op();
    logic [9*DW-1:0] v;
    for (int e = 0; e < 9; e++) v[e*DW +: DW] = DW'($urandom_range(0, 255));
    return v;
  endfunction

  function automatic bit model_grant(input logic [1:0] v);
    return v[rr_ptr] ? rr_ptr : ~rr_ptr;
  endfunction

  // Engine stub: result follows the trigger after stub_lat cycles; junk otherwise.
  always @(posedge clk) begin
    stub_vld   <= 1'b0;
    eng_dout_C <= ~stub_res;
    if (eng_trig) begin
      trig_cnt <= trig_cnt + 1;
      stub_cnt <= stub_silent ? 0 : stub_lat;
      stub_res <= ref_mul(eng_din_A, eng_din_B);
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_vld   <= 1'b1;
        eng_dout_C <= stub_res;
      end
    end
  end

  task automatic check(input string tag, input logic [18*DW-1:0] obs, input logic [18*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with DUT idle and the relevant req_valid already set.
  task automatic serve(input bit exp_id, input int hold, input bit keep);
    logic [18*DW-1:0] exp_c;
    int tc0, cyc;
    #1;
    check("grant", req_ready, exp_id ? 2'b10 : 2'b01);
    exp_c = exp_id ? ref_mul(a1, b1) : ref_mul(a0, b0);
    tc0 = trig_cnt;
    @(posedge clk);
    rr_ptr = ~exp_id;
    @(negedge clk);
    if (!keep) req_valid[exp_id] = 1'b0;
    if (exp_id) begin a1 = rnd_op(); b1 = rnd_op(); end
    else begin a0 = rnd_op(); b0 = rnd_op(); end
    check("load", {eng_en, eng_trig, busy, req_ready}, 5'b11100);
    cyc = 0;
    while (!rsp_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_seen", rsp_valid, 1'b1);
    for (int h = 0; h < hold; h++) begin
      stray = 1'b1;
      check("hold_ctl", {rsp_valid, busy, eng_en, req_ready}, 5'b11000);
      check("hold_c", rsp_c, exp_c);
      @(negedge clk);
    end
    stray = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("rsp_id", rsp_id, exp_id);
    check("rsp_c", rsp_c, exp_c);
    check("rsp_err", rsp_err, 1'b0);
    check("trig_once", trig_cnt - tc0, 1);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_after", {rsp_valid, busy, eng_en}, 3'b000);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic [18*DW-1:0] ident;

    // Reset state, with both requesters asserting.
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    check("rst_ctl", {rsp_valid, rsp_err, eng_en, eng_trig, busy, req_ready}, 7'b0);
    check("rst_id", rsp_id, 1'b0);
    check("rst_c", rsp_c, '0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    rr_ptr = 1'b0;
    @(negedge clk);

    // Identity: A = I, B = 1..9 (transposed), requester 0.
    a0 = 72'h01_00_00_00_01_00_00_00_01;
    b0 = 72'h09_08_07_06_05_04_03_02_01;
    ident = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        ident[(i*3+j)*2*DW +: 2*DW] = 16'(j*3 + i + 1);
    check("ident_model", ref_mul(a0, b0), ident);
    stub_lat = 2;
    req_valid = 2'b01;
    serve(model_grant(req_valid), 0, 1'b0);

    // Reset while RUN waits on a silent engine: job is discarded.
    stub_silent = 1'b1;
    req_valid = 2'b10;
    #1;
    check("rst_grant", req_ready, 2'b10);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    check("run_ctl", {eng_en, eng_trig, busy}, 3'b101);
    repeat (2) @(negedge clk);
    check("run_wait", rsp_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst", {busy, eng_en, rsp_valid}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    rr_ptr = 1'b0;
    stub_silent = 1'b0;
    cyc = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || busy) cyc++;
    end
    check("no_rsp_after_rst", cyc, 0);

    // A request dropped before handshake must not move the round-robin pointer.
    req_valid = 2'b10;
    #1;
    check("drop_ready", req_ready, 2'b10);
    #2;
    req_valid = 2'b00;
    @(negedge clk);
    check("drop_idle", busy, 1'b0);

    // Both requesters continuously valid: grants alternate 0,1,0,1.
    a0 = rnd_op(); b0 = rnd_op(); a1 = rnd_op(); b1 = rnd_op();
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      bit g;
      g = model_grant(req_valid);
      check("rr_order", g, n[0]);
      stub_lat = $urandom_range(1, 4);
      serve(g, (n == 1) ? 5 : $urandom_range(0, 2), 1'b1);
    end
    req_valid = 2'b00;
    @(negedge clk);

`ifdef MAT_SCHED_TIMEOUT_EN
    // Silent engine: watchdog aborts after 16 RUN cycles with a zeroed result.
    stub_silent = 1'b1;
    req_valid = 2'b01;
    #1;
    check("tmo_grant", req_ready, {1'b0, ~rr_ptr | 1'b1} & 2'b01);
    @(posedge clk);
    rr_ptr = 1'b1;
    @(negedge clk);
    req_valid = 2'b00;
    cyc = 0;
    @(negedge clk);
    while (!rsp_valid && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("tmo_cycles", cyc, 16);
    check("tmo_err", rsp_err, 1'b1);
    check("tmo_c", rsp_c, '0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    stub_silent = 1'b0;
    // Completion on the very cycle the watchdog would fire counts as normal.
    stub_lat = 15;
    req_valid = 2'b01;
    serve(model_grant(req_valid), 0, 1'b0);
`else
    // Without the watchdog, RUN waits indefinitely on a silent engine.
    stub_silent = 1'b1;
    req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (40) @(negedge clk);
    check("no_tmo", {rsp_valid, busy, eng_en, rsp_err}, 4'b0110);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rr_ptr = 1'b0;
    stub_silent = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
